// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares two regfile write ports between two pipeline lanes and a queued
// long-latency result stream. Optional feature macro: WB_LL_BYPASS_EN (direct ll->port bypass).
module wb_port_arbiter #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int LLQ_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       l0_we,
  input  logic [REG_ADDR_W-1:0]      l0_waddr,
  input  logic [DATA_W-1:0]          l0_wdata,
  input  logic                       l0_num,
  input  logic                       l1_we,
  input  logic [REG_ADDR_W-1:0]      l1_waddr,
  input  logic [DATA_W-1:0]          l1_wdata,
  input  logic                       l1_num,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [REG_ADDR_W-1:0]      ll_waddr,
  input  logic [DATA_W-1:0]          ll_wdata,
  output logic                       rf_we0,
  output logic [REG_ADDR_W-1:0]      rf_waddr0,
  output logic [DATA_W-1:0]          rf_wdata0,
  output logic                       rf_we1,
  output logic [REG_ADDR_W-1:0]      rf_waddr1,
  output logic [DATA_W-1:0]          rf_wdata1,
  output logic                       stall_req,
  output logic [$clog2(LLQ_DEPTH):0] ll_count
);

  localparam int PTR_W  = $clog2(LLQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } ll_entry_t;

  ll_entry_t             mem_q [LLQ_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SCNT_W-1:0]     starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  rf_we0_q, rf_we0_d, rf_we1_q, rf_we1_d;
  logic [REG_ADDR_W-1:0] rf_waddr0_q, rf_waddr0_d, rf_waddr1_q, rf_waddr1_d;
  logic [DATA_W-1:0]     rf_wdata0_q, rf_wdata0_d, rf_wdata1_q, rf_wdata1_d;

  logic                  l0_act, l1_act, lane_conflict, l0_wr, l1_wr;
  logic                  ll_ready_int, push, bypass;
  logic [1:0]            n_pop;
  ll_entry_t             head, second, cand, incoming;

  // An ll entry is written only if its target is non-zero and no surviving lane write hits it;
  // lane instructions are always younger than anything already returned by the ll unit.
  function automatic logic entry_writes(input ll_entry_t e,
                                        input logic w0, input logic [REG_ADDR_W-1:0] a0,
                                        input logic w1, input logic [REG_ADDR_W-1:0] a1);
    return (e.addr != '0) && !(w0 && (e.addr == a0)) && !(w1 && (e.addr == a1));
  endfunction

  always_comb begin
    l0_act        = l0_we && (l0_waddr != '0);
    l1_act        = l1_we && (l1_waddr != '0);
    lane_conflict = l0_act && l1_act && (l0_waddr == l1_waddr);
    // On a same-register collision the younger (num==0) lane wins.
    l0_wr         = l0_act && !(lane_conflict && l0_num);
    l1_wr         = l1_act && !(lane_conflict && !l0_num);
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    head         = mem_q[rd_ptr_q];
    second       = mem_q[rd_ptr_q + PTR_W'(1)];
    cand         = head;
    incoming     = '{addr: ll_waddr, data: ll_wdata};
    ll_ready_int = count_q < CNT_W'(LLQ_DEPTH);
    n_pop        = 2'd0;
    bypass       = 1'b0;
    rf_we0_d     = l0_wr;
    rf_waddr0_d  = l0_wr ? l0_waddr : '0;
    rf_wdata0_d  = l0_wr ? l0_wdata : '0;
    rf_we1_d     = l1_wr;
    rf_waddr1_d  = l1_wr ? l1_waddr : '0;
    rf_wdata1_d  = l1_wr ? l1_wdata : '0;

    if (!l0_wr) begin
      if (count_q != '0) begin
        n_pop = 2'd1;
        if (entry_writes(head, l0_wr, l0_waddr, l1_wr, l1_waddr)) begin
          rf_we0_d    = 1'b1;
          rf_waddr0_d = head.addr;
          rf_wdata0_d = head.data;
        end
      end
`ifdef WB_LL_BYPASS_EN
      else if (ll_valid) begin
        bypass = 1'b1;
        if (entry_writes(incoming, l0_wr, l0_waddr, l1_wr, l1_waddr)) begin
          rf_we0_d    = 1'b1;
          rf_waddr0_d = incoming.addr;
          rf_wdata0_d = incoming.data;
        end
      end
`endif
    end

    if (!l1_wr) begin
      if (count_q > CNT_W'(n_pop)) begin
        cand  = (n_pop == 2'd0) ? head : second;
        n_pop = n_pop + 2'd1;
        if (entry_writes(cand, l0_wr, l0_waddr, l1_wr, l1_waddr)) begin
          rf_we1_d    = 1'b1;
          rf_waddr1_d = cand.addr;
          rf_wdata1_d = cand.data;
        end
      end
`ifdef WB_LL_BYPASS_EN
      else if ((count_q == '0) && ll_valid && !bypass) begin
        bypass = 1'b1;
        if (entry_writes(incoming, l0_wr, l0_waddr, l1_wr, l1_waddr)) begin
          rf_we1_d    = 1'b1;
          rf_waddr1_d = incoming.addr;
          rf_wdata1_d = incoming.data;
        end
      end
`endif
    end

    push     = ll_valid && ll_ready_int && !bypass;
    count_d  = count_q + CNT_W'(push) - CNT_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);

    // Head-wait counter saturates at STARVE_MAX; the stall holds until something drains.
    if ((count_q == '0) || (n_pop != 2'd0)) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      starve_d = (starve_q < SCNT_W'(STARVE_MAX)) ? starve_q + SCNT_W'(1) : starve_q;
      stall_d  = stall_q || (starve_q == SCNT_W'(STARVE_MAX));
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
      rf_we0_q    <= 1'b0;
      rf_waddr0_q <= '0;
      rf_wdata0_q <= '0;
      rf_we1_q    <= 1'b0;
      rf_waddr1_q <= '0;
      rf_wdata1_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      rf_we0_q    <= rf_we0_d;
      rf_waddr0_q <= rf_waddr0_d;
      rf_wdata0_q <= rf_wdata0_d;
      rf_we1_q    <= rf_we1_d;
      rf_waddr1_q <= rf_waddr1_d;
      rf_wdata1_q <= rf_wdata1_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count and pointers alone decide which
  // entries are live, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= incoming;
  end

  assign ll_ready  = ll_ready_int;
  assign ll_count  = count_q;
  assign stall_req = stall_q;
  assign rf_we0    = rf_we0_q;
  assign rf_waddr0 = rf_waddr0_q;
  assign rf_wdata0 = rf_wdata0_q;
  assign rf_we1    = rf_we1_q;
  assign rf_waddr1 = rf_waddr1_q;
  assign rf_wdata1 = rf_wdata1_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table for lane-only cycles plus hand-written sequences
// for ll latency, fill/starvation, silent pops and mid-operation reset.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        l0_we, l0_num, l1_we, l1_num, ll_valid;
  logic [4:0]  l0_waddr, l1_waddr, ll_waddr;
  logic [31:0] l0_wdata, l1_wdata, ll_wdata;
  logic        ll_ready, rf_we0, rf_we1, stall_req;
  logic [4:0]  rf_waddr0, rf_waddr1;
  logic [31:0] rf_wdata0, rf_wdata1;
  logic [1:0]  ll_count;

  int n_cmp = 0;
  int n_bad = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .l0_we(l0_we), .l0_waddr(l0_waddr), .l0_wdata(l0_wdata), .l0_num(l0_num),
    .l1_we(l1_we), .l1_waddr(l1_waddr), .l1_wdata(l1_wdata), .l1_num(l1_num),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .rf_we0(rf_we0), .rf_waddr0(rf_waddr0), .rf_wdata0(rf_wdata0),
    .rf_we1(rf_we1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
    .stall_req(stall_req), .ll_count(ll_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        l0_we;
    logic [4:0]  l0_waddr;
    logic [31:0] l0_wdata;
    logic        l0_num;
    logic        l1_we;
    logic [4:0]  l1_waddr;
    logic [31:0] l1_wdata;
    logic        l1_num;
    logic        e_we0;
    logic [4:0]  e_a0;
    logic [31:0] e_d0;
    logic        e_we1;
    logic [4:0]  e_a1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_l0(input logic we, input logic [4:0] a, input logic [31:0] d, input logic num);
    l0_we = we; l0_waddr = a; l0_wdata = d; l0_num = num;
  endtask

  task automatic set_l1(input logic we, input logic [4:0] a, input logic [31:0] d, input logic num);
    l1_we = we; l1_waddr = a; l1_wdata = d; l1_num = num;
  endtask

  task automatic set_ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    ll_valid = v; ll_waddr = a; ll_wdata = d;
  endtask

  task automatic idle_lanes();
    set_l0(1'b0, 5'd0, 32'h0, 1'b0);
    set_l1(1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic busy_lanes();
    set_l0(1'b1, 5'd1, 32'h1111, 1'b1);
    set_l1(1'b1, 5'd2, 32'h2222, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hA, 1'b1, 1'b1, 5'd5, 32'hB, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hB};
    vecs[1] = '{1'b1, 5'd5, 32'hA, 1'b0, 1'b1, 5'd5, 32'hB, 1'b1,
                1'b1, 5'd5, 32'hA, 1'b0, 5'd0, 32'h0};
    vecs[2] = '{1'b1, 5'd1, 32'h11, 1'b0, 1'b1, 5'd2, 32'h22, 1'b1,
                1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22};
    vecs[3] = '{1'b1, 5'd0, 32'h33, 1'b0, 1'b1, 5'd3, 32'h44, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h44};
    vecs[4] = '{1'b0, 5'd6, 32'h55, 1'b0, 1'b0, 5'd7, 32'h66, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[5] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 1'b0, 5'd31, 32'h1, 1'b0,
                1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0};
    vecs[6] = '{1'b0, 5'd4, 32'h1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[7] = '{1'b1, 5'd0, 32'h1, 1'b1, 1'b1, 5'd0, 32'h2, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0};

    idle_lanes();
    set_ll(1'b0, 5'd0, 32'h0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_we0", 64'(rf_we0), 64'(0));
    check("rst_we1", 64'(rf_we1), 64'(0));
    check("rst_waddr0", 64'(rf_waddr0), 64'(0));
    check("rst_wdata1", 64'(rf_wdata1), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    check("rst_ready", 64'(ll_ready), 64'(1));
    check("rst_count", 64'(ll_count), 64'(0));
    rst_n = 1'b1;
    step();

    // Lane-only vector table
    for (int i = 0; i < 8; i++) begin
      set_l0(vecs[i].l0_we, vecs[i].l0_waddr, vecs[i].l0_wdata, vecs[i].l0_num);
      set_l1(vecs[i].l1_we, vecs[i].l1_waddr, vecs[i].l1_wdata, vecs[i].l1_num);
      step();
      check($sformatf("v%0d_we0", i), 64'(rf_we0), 64'(vecs[i].e_we0));
      check($sformatf("v%0d_we1", i), 64'(rf_we1), 64'(vecs[i].e_we1));
      if (vecs[i].e_we0) begin
        check($sformatf("v%0d_a0", i), 64'(rf_waddr0), 64'(vecs[i].e_a0));
        check($sformatf("v%0d_d0", i), 64'(rf_wdata0), 64'(vecs[i].e_d0));
      end
      if (vecs[i].e_we1) begin
        check($sformatf("v%0d_a1", i), 64'(rf_waddr1), 64'(vecs[i].e_a1));
        check($sformatf("v%0d_d1", i), 64'(rf_wdata1), 64'(vecs[i].e_d1));
      end
      check($sformatf("v%0d_cnt", i), 64'(ll_count), 64'(0));
    end
    idle_lanes();
    step();

    // Single ll result with idle lanes
    set_ll(1'b1, 5'd7, 32'h77);
    step();
`ifdef WB_LL_BYPASS_EN
    check("ll1_we0", 64'(rf_we0), 64'(1));
    check("ll1_a0", 64'(rf_waddr0), 64'(7));
    check("ll1_d0", 64'(rf_wdata0), 64'(32'h77));
    check("ll1_cnt", 64'(ll_count), 64'(0));
`else
    check("ll1_we0", 64'(rf_we0), 64'(0));
    check("ll1_cnt", 64'(ll_count), 64'(1));
`endif
    set_ll(1'b0, 5'd0, 32'h0);
    step();
`ifdef WB_LL_BYPASS_EN
    check("ll2_we0", 64'(rf_we0), 64'(0));
`else
    check("ll2_we0", 64'(rf_we0), 64'(1));
    check("ll2_a0", 64'(rf_waddr0), 64'(7));
    check("ll2_d0", 64'(rf_wdata0), 64'(32'h77));
`endif
    check("ll2_cnt", 64'(ll_count), 64'(0));
    check("ll2_we1", 64'(rf_we1), 64'(0));

    // Fill while lanes own both ports, then starve and drain
    busy_lanes();
    set_ll(1'b1, 5'd10, 32'hA1);
    step();
    check("fill1_cnt", 64'(ll_count), 64'(1));
    check("fill1_rdy", 64'(ll_ready), 64'(1));
    set_ll(1'b1, 5'd11, 32'hA2);
    step();
    check("fill2_cnt", 64'(ll_count), 64'(2));
    check("fill2_rdy", 64'(ll_ready), 64'(0));
    check("fill2_stall", 64'(stall_req), 64'(0));
    set_ll(1'b1, 5'd12, 32'hA3);
    step();
    check("full_reject_cnt", 64'(ll_count), 64'(2));
    set_ll(1'b0, 5'd0, 32'h0);
    step();
    step();
    check("starve_pre_stall", 64'(stall_req), 64'(0));
    step();
    check("starve_stall", 64'(stall_req), 64'(1));
    step();
    check("starve_hold", 64'(stall_req), 64'(1));
    check("starve_lane_we0", 64'(rf_we0), 64'(1));
    check("starve_lane_a0", 64'(rf_waddr0), 64'(1));
    idle_lanes();
    step();
    check("drain_we0", 64'(rf_we0), 64'(1));
    check("drain_a0", 64'(rf_waddr0), 64'(10));
    check("drain_d0", 64'(rf_wdata0), 64'(32'hA1));
    check("drain_we1", 64'(rf_we1), 64'(1));
    check("drain_a1", 64'(rf_waddr1), 64'(11));
    check("drain_d1", 64'(rf_wdata1), 64'(32'hA2));
    check("drain_cnt", 64'(ll_count), 64'(0));
    check("drain_stall", 64'(stall_req), 64'(0));
    check("drain_rdy", 64'(ll_ready), 64'(1));
    step();
    check("post_drain_we0", 64'(rf_we0), 64'(0));
    check("post_drain_we1", 64'(rf_we1), 64'(0));

    // Head x9 squashed by a same-cycle lane1 write to x9
    busy_lanes();
    set_ll(1'b1, 5'd9, 32'h99);
    step();
    check("hit_cnt1", 64'(ll_count), 64'(1));
    set_ll(1'b0, 5'd0, 32'h0);
    set_l0(1'b0, 5'd0, 32'h0, 1'b0);
    set_l1(1'b1, 5'd9, 32'hB9, 1'b0);
    step();
    check("hit_we0", 64'(rf_we0), 64'(0));
    check("hit_we1", 64'(rf_we1), 64'(1));
    check("hit_a1", 64'(rf_waddr1), 64'(9));
    check("hit_d1", 64'(rf_wdata1), 64'(32'hB9));
    check("hit_cnt0", 64'(ll_count), 64'(0));
    idle_lanes();
    step();
    check("hit_after_we0", 64'(rf_we0), 64'(0));
    check("hit_after_we1", 64'(rf_we1), 64'(0));

    // Entry targeting x0 drains without a write
    busy_lanes();
    set_ll(1'b1, 5'd0, 32'h5A);
    step();
    check("x0_cnt1", 64'(ll_count), 64'(1));
    set_ll(1'b0, 5'd0, 32'h0);
    idle_lanes();
    step();
    check("x0_we0", 64'(rf_we0), 64'(0));
    check("x0_we1", 64'(rf_we1), 64'(0));
    check("x0_cnt0", 64'(ll_count), 64'(0));

    // Reset with two queued entries
    busy_lanes();
    set_ll(1'b1, 5'd20, 32'hC0);
    step();
    set_ll(1'b1, 5'd21, 32'hC1);
    step();
    check("mrst_pre_cnt", 64'(ll_count), 64'(2));
    set_ll(1'b0, 5'd0, 32'h0);
    idle_lanes();
    rst_n = 1'b0;
    #1;
    check("mrst_cnt", 64'(ll_count), 64'(0));
    check("mrst_rdy", 64'(ll_ready), 64'(1));
    check("mrst_we0", 64'(rf_we0), 64'(0));
    check("mrst_we1", 64'(rf_we1), 64'(0));
    check("mrst_stall", 64'(stall_req), 64'(0));
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mrst_post%0d_we0", k), 64'(rf_we0), 64'(0));
      check($sformatf("mrst_post%0d_we1", k), 64'(rf_we1), 64'(0));
      check($sformatf("mrst_post%0d_cnt", k), 64'(ll_count), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
